event_synchronizer: RTL and testbench

EVENT_SYNCHRONIZER -- requirements
Module: event_synchronizer

---
 rtl/event_sync_pkg.sv | 11 +
 rtl/event_sync_channel.sv | 78 +++++++
 rtl/event_synchronizer.sv | 42 ++++
 tb/tb_event_synchronizer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/event_sync_pkg.sv
// event_sync_pkg: shared types for the event synchronizer slice
package event_sync_pkg;

    typedef enum logic [1:0] {
        LEVEL_HIGH = 2'b00,
        RISING     = 2'b01,
        FALLING    = 2'b10,
        BOTH       = 2'b11
    } edge_mode_t;

endpackage

// File: rtl/event_sync_channel.sv
// event_sync_channel: one channel of sync chain, glitch filter, edge detect and sticky pending
module event_sync_channel
    import event_sync_pkg::*;
#(
    parameter int   FLOP_NUMBER   = 3,
    parameter int   FILTER_CYCLES = 4,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       async_i,
    input  edge_mode_t mode_i,
    input  logic       enable_i,
    input  logic       clear_i,
    output logic       level_o,
    output logic       event_o,
    output logic       pending_o
);

    localparam int CW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;

`ifdef XILINX
    (* ASYNC_REG = "TRUE" *)
`endif
    logic [FLOP_NUMBER-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   prev_q;
    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   fire;
    logic                   set;

    assign s = sync_q[FLOP_NUMBER-1];

    // synchronizer shift chain; the oldest stage is the synced value
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= {FLOP_NUMBER{RESET_VALUE}};
        else       sync_q <= {sync_q[FLOP_NUMBER-2:0], async_i};
    end

    // level follows s only after it has disagreed for FILTER_CYCLES+1 edges in a row
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_o <= RESET_VALUE;
            cnt_q   <= '0;
        end else if (s == level_o) begin
            cnt_q   <= '0;
        end else if (cnt_q == CW'(FILTER_CYCLES)) begin
            level_o <= s;
            cnt_q   <= '0;
        end else begin
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    // edge qualification by mode; LEVEL_HIGH also keeps pending asserted while high
    always_comb begin
        rise = level_o & ~prev_q;
        fall = ~level_o & prev_q;
        fire = (mode_i == FALLING) ? fall : (mode_i == BOTH) ? (rise | fall) : rise;
        set  = enable_i & (fire | ((mode_i == LEVEL_HIGH) & level_o));
    end

    // previous level, registered event pulse and sticky pending (set beats clear)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q    <= RESET_VALUE;
            event_o   <= 1'b0;
            pending_o <= 1'b0;
        end else begin
            prev_q    <= level_o;
            event_o   <= fire;
            pending_o <= set | (pending_o & ~clear_i);
        end
    end

endmodule

// File: rtl/event_synchronizer.sv
// event_synchronizer: multi-channel asynchronous event capture with interrupt output
module event_synchronizer
    import event_sync_pkg::*;
#(
    parameter int                  CHANNELS      = 8,
    parameter int                  FLOP_NUMBER   = 3,
    parameter int                  FILTER_CYCLES = 4,
    parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CHANNELS-1:0]   async_i,
    input  logic [2*CHANNELS-1:0] mode_i,
    input  logic [CHANNELS-1:0]   enable_i,
    input  logic [CHANNELS-1:0]   clear_i,
    output logic [CHANNELS-1:0]   level_o,
    output logic [CHANNELS-1:0]   event_o,
    output logic [CHANNELS-1:0]   pending_o,
    output logic                  irq_o
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        event_sync_channel #(
            .FLOP_NUMBER  (FLOP_NUMBER),
            .FILTER_CYCLES(FILTER_CYCLES),
            .RESET_VALUE  (RESET_VALUE[i])
        ) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .async_i  (async_i[i]),
            .mode_i   (edge_mode_t'(mode_i[2*i +: 2])),
            .enable_i (enable_i[i]),
            .clear_i  (clear_i[i]),
            .level_o  (level_o[i]),
            .event_o  (event_o[i]),
            .pending_o(pending_o[i])
        );
    end

    assign irq_o = |(pending_o & enable_i);

endmodule

// File: tb/tb_event_synchronizer.sv
// tb_event_synchronizer: directed and randomized checks against a behavioural model
module tb_event_synchronizer;
    import event_sync_pkg::*;

    localparam int CH = 4;
    localparam int FN = 3;
    localparam int FC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] async_v = '0;
    logic [2*CH-1:0] mode = {2'b00, 2'b10, 2'b11, 2'b01};
    logic [CH-1:0] en = '1;
    logic [CH-1:0] clr = '0;
    logic [CH-1:0] level, evt, pend;
    logic          irq;

    int n_checks = 0;
    int n_fail   = 0;

    event_synchronizer #(
        .CHANNELS     (CH),
        .FLOP_NUMBER  (FN),
        .FILTER_CYCLES(FC),
        .RESET_VALUE  ({CH{1'b0}})
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .async_i  (async_v),
        .mode_i   (mode),
        .enable_i (en),
        .clear_i  (clr),
        .level_o  (level),
        .event_o  (evt),
        .pending_o(pend),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #4;
    endtask

    // behavioural model: s is the input seen FN edges ago; level moves after FC+1 disagreeing samples
    bit            mq [CH][$];
    logic [CH-1:0] m_lvl, m_prev, m_evt, m_pend;
    int            m_run [CH];
    bit            m_valid = 0;

    always @(posedge clk) begin
        bit s, l0, p0, rise, fall, ev;
        edge_mode_t md;
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                mq[c] = {};
                repeat (FN) mq[c].push_back(1'b0);
                m_run[c] = 0;
            end
            m_lvl = '0; m_prev = '0; m_evt = '0; m_pend = '0;
            m_valid = 1;
        end else if (m_valid) begin
            for (int c = 0; c < CH; c++) begin
                s  = mq[c][0];
                l0 = m_lvl[c];
                p0 = m_prev[c];
                md = edge_mode_t'(mode[2*c +: 2]);
                rise = l0 && !p0;
                fall = !l0 && p0;
                case (md)
                    FALLING: ev = fall;
                    BOTH:    ev = rise || fall;
                    default: ev = rise;
                endcase
                m_evt[c] = ev;
                if (en[c] && (ev || (md == LEVEL_HIGH && l0))) m_pend[c] = 1'b1;
                else if (clr[c])                                m_pend[c] = 1'b0;
                m_prev[c] = l0;
                m_run[c] = (s != l0) ? m_run[c] + 1 : 0;
                if (m_run[c] == FC + 1) begin
                    m_lvl[c] = s;
                    m_run[c] = 0;
                end
                void'(mq[c].pop_front());
                mq[c].push_back(async_v[c]);
            end
        end
    end

    // compare DUT against the model each cycle, away from the clock edge
    always @(posedge clk) begin
        #3;
        if (m_valid) begin
            check("level", 32'(level), 32'(m_lvl));
            check("event", 32'(evt), 32'(m_evt));
            check("pending", 32'(pend), 32'(m_pend));
            check("irq", 32'(irq), 32'(|(m_pend & en)));
        end
    end

    initial begin
        logic saw;
        tick; tick;
        check("rst_level", 32'(level), 32'h0);
        check("rst_event", 32'(evt), 32'h0);
        check("rst_pending", 32'(pend), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        repeat (3) tick;

        // channel 0 rising: pulse after edge FN+FC+2 = 9
        async_v[0] = 1'b1;
        repeat (8) tick;
        check("ch0_ev_early", 32'(evt[0]), 32'h0);
        tick;
        check("ch0_ev", 32'(evt[0]), 32'h1);
        check("ch0_pend", 32'(pend[0]), 32'h1);
        check("ch0_irq", 32'(irq), 32'h1);
        tick;
        check("ch0_ev_once", 32'(evt[0]), 32'h0);

        // 3-cycle glitch on channel 1 must vanish
        async_v[1] = 1'b1;
        repeat (3) tick;
        async_v[1] = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            tick;
            saw = saw | evt[1] | level[1];
        end
        check("glitch_seen", 32'(saw), 32'h0);
        check("glitch_pend", 32'(pend[1]), 32'h0);

        // channel 2 falling; clear coinciding with a new event loses to the set
        async_v[2] = 1'b1;
        repeat (15) tick;
        async_v[2] = 1'b0;
        repeat (9) tick;
        check("ch2_ev1", 32'(evt[2]), 32'h1);
        check("ch2_pend1", 32'(pend[2]), 32'h1);
        async_v[2] = 1'b1;
        repeat (15) tick;
        async_v[2] = 1'b0;
        repeat (8) tick;
        clr[2] = 1'b1;
        tick;
        clr[2] = 1'b0;
        check("ch2_ev2", 32'(evt[2]), 32'h1);
        check("ch2_set_wins", 32'(pend[2]), 32'h1);
        tick;
        clr[2] = 1'b1;
        tick;
        clr[2] = 1'b0;
        check("ch2_cleared", 32'(pend[2]), 32'h0);

        // channel 3 level-high holds pending while the level is high
        async_v[3] = 1'b1;
        repeat (12) tick;
        check("ch3_pend", 32'(pend[3]), 32'h1);
        clr[3] = 1'b1;
        tick;
        clr[3] = 1'b0;
        check("ch3_hold", 32'(pend[3]), 32'h1);
        async_v[3] = 1'b0;
        repeat (12) tick;
        check("ch3_low", 32'(level[3]), 32'h0);
        clr[3] = 1'b1;
        tick;
        clr[3] = 1'b0;
        check("ch3_cleared", 32'(pend[3]), 32'h0);

        // enable low: event still pulses, no pending, no irq
        clr[0] = 1'b1;
        tick;
        clr[0] = 1'b0;
        en[0] = 1'b0;
        async_v[0] = 1'b0;
        repeat (12) tick;
        async_v[0] = 1'b1;
        repeat (9) tick;
        check("dis_ev", 32'(evt[0]), 32'h1);
        check("dis_pend", 32'(pend[0]), 32'h0);
        check("dis_irq", 32'(irq), 32'h0);

        // reset mid-filter discards the event and clears pending
        en[0] = 1'b1;
        async_v[0] = 1'b0;
        async_v[3] = 1'b1;
        repeat (12) tick;
        check("pre_rst_pend3", 32'(pend[3]), 32'h1);
        async_v[0] = 1'b1;
        repeat (6) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        async_v = '0;
        check("mid_rst_level", 32'(level), 32'h0);
        check("mid_rst_event", 32'(evt), 32'h0);
        check("mid_rst_pend", 32'(pend), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        saw = 1'b0;
        repeat (20) begin
            tick;
            saw = saw | (|evt);
        end
        check("post_rst_quiet", 32'(saw), 32'h0);

        // randomized traffic checked every cycle by the model
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 7) == 0) async_v[c] = ~async_v[c];
            if ($urandom_range(0, 63) == 0)  en = CH'($urandom);
            if ($urandom_range(0, 127) == 0) mode = (2*CH)'($urandom);
            clr = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
            rst = ($urandom_range(0, 399) == 0);
            tick;
        end
        rst = 1'b0;
        clr = '0;
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
